stack_mask_sequencer: RTL and testbench
=======================================

# stack_mask_sequencer

Walks a push/pop register bitmask (as carried in the pre-decode `push`/`pop` fields) and emits one stack bus request per set bit, in architectural order, while tracking the stack pointer. Sits between the decoder/microsequencer and the bus interface unit; it is the parametrised successor to the fixed 16-bit mask handling, generalised in mask width, word size and address width, and adds pop ordering, back-pressure and abort.

## Interface
Parameters:
- `MASK_W`, 16, number of mask bits; bit i maps to stack slot i (bit 0 = AW … bit 15 = IMM)
- `ADDR_W`, 16, stack pointer / address width
- `WORD_BYTES`, 2, SP step per transfer
- `IDX_W`, $clog2(MASK_W), width of `req_index`

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin sequence; sampled only in IDLE
- `is_pop`  in  1  0 = push sequence, 1 = pop sequence; captured with `start`
- `mask`  in  MASK_W  slots to transfer; captured with `start`
- `sp_in`  in  ADDR_W  SP at sequence start; captured with `start`
- `abort`  in  1  synchronous cancel; overrides everything except reset
- `busy`  out  1  high in RUN
- `req_valid`  out  1  request pending
- `req_ready`  in  1  BIU accepts request when `req_valid && req_ready`
- `req_index`  out  IDX_W  slot number being transferred
- `req_addr`  out  ADDR_W  stack address of transfer
- `req_write`  out  1  1 = write (push), 0 = read (pop)
- `done`  out  1  one-cycle pulse at sequence completion
- `sp_out`  out  ADDR_W  final SP; valid when `done`, held until next `done`

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 latches `mask`→`remaining`, `sp_in`→`sp`, `is_pop`→`mode`. Nonzero mask → RUN; zero mask → DONE.
- RUN: `req_valid`=1, `req_write`=!mode.
  - Push: `req_index` = lowest set bit of `remaining`; `req_addr` = `sp` − WORD_BYTES.
  - Pop: `req_index` = highest set bit of `remaining`; `req_addr` = `sp`.
  - On handshake: clear bit `req_index`; `sp` −= WORD_BYTES (push) / += WORD_BYTES (pop); if `remaining` becomes zero → DONE.
  - No handshake: all request outputs held stable.
- DONE: `done`=1, `sp_out`=`sp`; → IDLE next cycle.
- Arithmetic modulo 2^ADDR_W: push from `sp`=0 yields address 2^ADDR_W−WORD_BYTES; pop wraps 2^ADDR_W−WORD_BYTES → 0.
- `start` in RUN or DONE ignored (no queueing).
- `abort`=1 in any state → IDLE next cycle, `remaining` cleared, no `done`, `sp_out` unchanged. `abort` in same cycle as a handshake: transfer counts for BIU, but sequencer still goes IDLE without `done`.
- `start` and `abort` together in IDLE: abort wins, start dropped.
- Reset (any state, async): state IDLE; `busy`, `req_valid`, `req_write`, `done` = 0; `req_index`, `req_addr`, `sp_out` = 0; internal `remaining`, `sp` = 0. Mid-sequence reset abandons sequence silently.

## Timing
- All outputs registered or decoded from registered state only; no combinational path from `req_ready`, `start` or `abort` to any output.
- `start` at cycle 0 → first `req_valid` at cycle 1.
- N set bits, `req_ready` tied high: requests in cycles 1..N, `done` in cycle N+1, `busy` low at N+1, new `start` accepted at N+2.
- Zero mask: `done` at cycle 1.
- Each stall cycle of `req_ready`=0 adds exactly one cycle.
- Throughput one transfer per cycle.

## Test plan
- Push, mask=0x00FF, sp_in=0x0100, ready high → indices 0..7 at cycles 1..8, addresses 0x00FE,0x00FC…0x00F0, `req_write`=1, `done` cycle 9, `sp_out`=0x00F0.
- Pop, mask=0x00FF, sp_in=0x00F0 → indices 7..0, addresses 0x00F0…0x00FE, `req_write`=0, `sp_out`=0x0100.
- Push mask=0x2401, sp_in=0x0000, ready toggled 1,0,1,0,1 → indices 0,10,13 at 0xFFFE,0xFFFC,0xFFFA; outputs stable across stalls; `done` cycle 6, `sp_out`=0xFFFA.
- mask=0x0000, sp_in=0x1234 → no `req_valid`, `done` cycle 1, `sp_out`=0x1234.
- Push mask=0x000F, `abort` at cycle 2 (with handshake) → IDLE cycle 3, no `done`, `sp_out` keeps prior value; `start` during RUN ignored.
- MASK_W=8, WORD_BYTES=4, ADDR_W=20: pop mask=0x81, sp_in=0xFFFFC → index 7 @0xFFFFC, index 0 @0x00000, `sp_out`=0x00004; assert `reset_n` low mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/stack_mask_sequencer.sv
// Walks a push/pop register mask and issues one stack bus request per set bit,
// lowest-first for pushes and highest-first for pops, while tracking the stack pointer.
module stack_mask_sequencer #(
    parameter int MASK_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int WORD_BYTES = 2,
    parameter int IDX_W      = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_pop,
    input  logic [MASK_W-1:0] mask,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic              abort,
    output logic              busy,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [IDX_W-1:0]  req_index,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_write,
    output logic              done,
    output logic [ADDR_W-1:0] sp_out
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [MASK_W-1:0] remaining, remaining_next;
    logic [ADDR_W-1:0] sp, sp_next;
    logic [ADDR_W-1:0] sp_out_q, sp_out_next;
    logic              mode, mode_next;
    logic [IDX_W-1:0]  low_idx, high_idx, sel_idx;
    logic              run, handshake;

    // Priority encoders over the registered mask; the later assignment wins.
    always_comb begin
        low_idx  = '0;
        high_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (remaining[i]) low_idx = IDX_W'(i);
        end
        for (int i = 0; i < MASK_W; i++) begin
            if (remaining[i]) high_idx = IDX_W'(i);
        end
    end

    assign sel_idx   = mode ? high_idx : low_idx;
    assign run       = (state == RUN);
    assign handshake = run && req_ready;

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        sp_next        = sp;
        sp_out_next    = sp_out_q;
        mode_next      = mode;
        case (state)
            IDLE: begin
                if (start) begin
                    remaining_next = mask;
                    sp_next        = sp_in;
                    mode_next      = is_pop;
                    if (mask == '0) begin
                        state_next  = DONE;
                        sp_out_next = sp_in;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (handshake) begin
                    remaining_next = remaining & ~(MASK_W'(1) << sel_idx);
                    sp_next        = mode ? (sp + STEP) : (sp - STEP);
                    if (remaining_next == '0) begin
                        state_next  = DONE;
                        sp_out_next = sp_next;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort drops everything, including a start seen in the same cycle.
        if (abort) begin
            state_next     = IDLE;
            remaining_next = '0;
            sp_next        = sp;
            mode_next      = mode;
            sp_out_next    = sp_out_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            sp        <= '0;
            sp_out_q  <= '0;
            mode      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            sp        <= sp_next;
            sp_out_q  <= sp_out_next;
            mode      <= mode_next;
        end
    end

    // Request outputs decode only registered state and read as zero outside RUN.
    assign busy      = run;
    assign req_valid = run;
    assign req_write = run && !mode;
    assign req_index = run ? sel_idx : '0;
    assign req_addr  = run ? (mode ? sp : (sp - STEP)) : '0;
    assign done      = (state == DONE);
    assign sp_out    = sp_out_q;

endmodule

// File: tb/tb_stack_mask_sequencer.sv
// Directed bench for stack_mask_sequencer: a default 16-bit instance and an
// 8-slot / 4-byte / 20-bit-address instance, checked against hand-computed vectors.
module tb_stack_mask_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        start, is_pop, abort, req_ready;
    logic [15:0] mask, sp_in;
    logic        busy, req_valid, req_write, done;
    logic [3:0]  req_index;
    logic [15:0] req_addr, sp_out;

    logic        b_start, b_is_pop, b_abort, b_req_ready;
    logic [7:0]  b_mask;
    logic [19:0] b_sp_in;
    logic        b_busy, b_req_valid, b_req_write, b_done;
    logic [2:0]  b_req_index;
    logic [19:0] b_req_addr, b_sp_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_mask_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_pop(is_pop), .mask(mask),
        .sp_in(sp_in), .abort(abort), .busy(busy), .req_valid(req_valid),
        .req_ready(req_ready), .req_index(req_index), .req_addr(req_addr),
        .req_write(req_write), .done(done), .sp_out(sp_out)
    );

    stack_mask_sequencer #(.MASK_W(8), .ADDR_W(20), .WORD_BYTES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .is_pop(b_is_pop), .mask(b_mask),
        .sp_in(b_sp_in), .abort(b_abort), .busy(b_busy), .req_valid(b_req_valid),
        .req_ready(b_req_ready), .req_index(b_req_index), .req_addr(b_req_addr),
        .req_write(b_req_write), .done(b_done), .sp_out(b_sp_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] idx, input logic [31:0] addr,
                             input logic [31:0] wr);
        check({tag, "_valid"}, 32'(req_valid), 32'd1);
        check({tag, "_busy"},  32'(busy),      32'd1);
        check({tag, "_index"}, 32'(req_index), idx);
        check({tag, "_addr"},  32'(req_addr),  addr);
        check({tag, "_write"}, 32'(req_write), wr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  t3_idx  [5] = '{4'd0, 4'd10, 4'd10, 4'd13, 4'd13};
    logic [15:0] t3_addr [5] = '{16'hFFFE, 16'hFFFC, 16'hFFFC, 16'hFFFA, 16'hFFFA};
    logic        t3_rdy  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset_n = 1'b0;
        start = 0; is_pop = 0; abort = 0; req_ready = 0; mask = '0; sp_in = '0;
        b_start = 0; b_is_pop = 0; b_abort = 0; b_req_ready = 0; b_mask = '0; b_sp_in = '0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(req_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sp_out", 32'(sp_out), 0);
        check("rst_addr", 32'(req_addr), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Push 0x00FF from 0x0100
        mask = 16'h00FF; sp_in = 16'h0100; is_pop = 0; req_ready = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            check_req("push", 32'(i), 32'h0100 - 32'(2 * (i + 1)), 1);
            tick();
        end
        check("push_done", 32'(done), 1);
        check("push_busy", 32'(busy), 0);
        check("push_valid", 32'(req_valid), 0);
        check("push_sp_out", 32'(sp_out), 32'h00F0);
        tick();
        check("push_done_pulse", 32'(done), 0);

        // Pop 0x00FF from 0x00F0
        mask = 16'h00FF; sp_in = 16'h00F0; is_pop = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            check_req("pop", 32'(7 - i), 32'h00F0 + 32'(2 * i), 0);
            tick();
        end
        check("pop_done", 32'(done), 1);
        check("pop_sp_out", 32'(sp_out), 32'h0100);
        tick();

        // Push 0x2401 from 0 with back-pressure
        mask = 16'h2401; sp_in = 16'h0000; is_pop = 0; start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 5; k++) begin
            req_ready = t3_rdy[k];
            check_req("stall", 32'(t3_idx[k]), 32'(t3_addr[k]), 1);
            tick();
        end
        req_ready = 1;
        check("stall_done", 32'(done), 1);
        check("stall_sp_out", 32'(sp_out), 32'hFFFA);
        tick();

        // Zero mask completes immediately
        mask = 16'h0000; sp_in = 16'h1234; is_pop = 0; start = 1;
        tick();
        start = 0;
        check("zero_valid", 32'(req_valid), 0);
        check("zero_done", 32'(done), 1);
        check("zero_sp_out", 32'(sp_out), 32'h1234);
        tick();
        check("zero_idle_done", 32'(done), 0);

        // Abort mid-run with a handshake; start during RUN ignored
        mask = 16'h000F; sp_in = 16'h0200; is_pop = 0; start = 1;
        tick();
        mask = 16'h0000; sp_in = 16'h5555;
        check_req("abort_c1", 0, 32'h01FE, 1);
        tick();
        start = 0;
        check_req("abort_c2", 1, 32'h01FC, 1);
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(req_valid), 0);
        check("abort_done", 32'(done), 0);
        check("abort_sp_out", 32'(sp_out), 32'h1234);
        tick();
        check("abort_no_done", 32'(done), 0);

        // Start and abort together in IDLE: start dropped
        mask = 16'h0000; sp_in = 16'h7777; start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        check("sa_busy", 32'(busy), 0);
        check("sa_done", 32'(done), 0);
        tick();
        check("sa_done2", 32'(done), 0);
        check("sa_sp_out", 32'(sp_out), 32'h1234);

        // Narrow instance: pop 0x81 from 0xFFFFC wraps to 0
        b_mask = 8'h81; b_sp_in = 20'hFFFFC; b_is_pop = 1; b_req_ready = 1; b_start = 1;
        tick();
        b_start = 0;
        check("b_c1_valid", 32'(b_req_valid), 1);
        check("b_c1_index", 32'(b_req_index), 7);
        check("b_c1_addr", 32'(b_req_addr), 32'hFFFFC);
        check("b_c1_write", 32'(b_req_write), 0);
        tick();
        check("b_c2_index", 32'(b_req_index), 0);
        check("b_c2_addr", 32'(b_req_addr), 32'h00000);
        tick();
        check("b_done", 32'(b_done), 1);
        check("b_sp_out", 32'(b_sp_out), 32'h00004);
        tick();

        // Asynchronous reset in the middle of a push sequence
        b_mask = 8'hFF; b_sp_in = 20'h00100; b_is_pop = 0; b_start = 1;
        tick();
        b_start = 0;
        check("b_run_valid", 32'(b_req_valid), 1);
        check("b_run_write", 32'(b_req_write), 1);
        check("b_run_addr", 32'(b_req_addr), 32'h000FC);
        #2;
        reset_n = 1'b0;
        #1;
        check("b_rst_busy", 32'(b_busy), 0);
        check("b_rst_valid", 32'(b_req_valid), 0);
        check("b_rst_write", 32'(b_req_write), 0);
        check("b_rst_index", 32'(b_req_index), 0);
        check("b_rst_addr", 32'(b_req_addr), 0);
        check("b_rst_done", 32'(b_done), 0);
        check("b_rst_sp_out", 32'(b_sp_out), 0);
        check("rst_a_sp_out", 32'(sp_out), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("b_post_rst_busy", 32'(b_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
